muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS CPU. Accepts MULT/MULTU/DIV/DIVU operations from the decode stage, runs a 32-iteration shift-add multiplier or restoring divider, and commits results into its own HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and drives a stall to the pipeline while the unit is busy.

---
 rtl/muldiv_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle HI/LO multiply/divide unit for the MIPS pipeline. It accepts
// MULT/MULTU/DIV/DIVU from decode and runs a 32-step shift-add multiplier or
// restoring divider on operand magnitudes. A final FIX cycle applies the sign
// correction and commits the result to the unit's own HI/LO registers. The
// unit also services MTHI/MTLO writes and MFHI/MFLO reads, and stalls the
// pipeline while an operation is in flight.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   start     : mul/div request, sampled only in IDLE
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa, opb  : rs / rt operands, sampled with start
//   mt_we     : MTHI/MTLO write request
//   mt_sel    : 1 = HI, 0 = LO (for mt_we and mf_req)
//   mt_data   : MTHI/MTLO write data
//   mf_req    : MFHI/MFLO read request
//   mf_data   : HI or LO selected by mt_sel (combinational)
//   stall     : request cannot be serviced this cycle
//   busy      : operation in flight
//   done      : one-cycle pulse after a commit
//   div_zero  : pulses with done when the divisor was zero
//   hi, lo    : architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    // Shared 64-bit accumulator:
    //   MUL: {partial product high, multiplier being shifted out}
    //   DIV: {remainder, quotient / dividend being shifted out}
    logic [63:0] r_acc;
    logic [31:0] r_opd;      // multiplicand or divisor magnitude
    logic        r_neg_lo;   // negate product (MUL) or quotient (DIV)
    logic        r_neg_hi;   // negate remainder (DIV only)
    logic        r_is_div;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    // -------------------------------------------------------------------
    // Operand preparation (IDLE)
    // -------------------------------------------------------------------
    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_sgn_ab;

    // MULT and DIV have op[0] = 0. Negating 0x80000000 wraps to itself,
    // which is already the correct unsigned magnitude.
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && opa[31]) ? (32'd0 - opa) : opa;
    assign w_abs_b  = (w_signed && opb[31]) ? (32'd0 - opb) : opb;
    assign w_sgn_ab = w_signed & (opa[31] ^ opb[31]);

    // -------------------------------------------------------------------
    // Multiply step: conditionally add multiplicand into the high half,
    // then shift the 65-bit {carry, acc} right by one.
    // -------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // -------------------------------------------------------------------
    // Divide step: shift {rem, quo} left, trial-subtract the divisor.
    // The shifted remainder can reach 33 bits; a non-negative difference
    // is always below the divisor so it fits back in 32.
    // -------------------------------------------------------------------
    logic [32:0] w_div_sh;
    logic [33:0] w_div_diff;
    logic [63:0] w_div_next;

    assign w_div_sh   = {r_acc[63:32], r_acc[31]};
    assign w_div_diff = {1'b0, w_div_sh} - {2'b00, r_opd};
    assign w_div_next = w_div_diff[33] ? {w_div_sh[31:0],   r_acc[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    // -------------------------------------------------------------------
    // Sign correction (FIX)
    // -------------------------------------------------------------------
    logic [63:0] w_fix_prod;
    logic [31:0] w_fix_quo;
    logic [31:0] w_fix_rem;

    assign w_fix_prod = r_neg_lo ? (64'd0 - r_acc)        : r_acc;
    assign w_fix_quo  = r_neg_lo ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_fix_rem  = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // -------------------------------------------------------------------
    // State machine and datapath registers
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= 64'd0;
            r_opd      <= 32'd0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= 5'd0;
                        r_opd    <= w_abs_b;
                        r_is_div <= op[1];
                        if (op[1] && (opb == 32'd0)) begin
                            // Divide by zero: preload the committed values
                            // and let FIX write them through uncorrected.
                            r_acc    <= {opa, 32'hFFFF_FFFF};
                            r_neg_lo <= 1'b0;
                            r_neg_hi <= 1'b0;
                            r_dz     <= 1'b1;
                            r_state  <= S_FIX;
                        end else begin
                            r_acc    <= {32'd0, w_abs_a};
                            r_neg_lo <= w_sgn_ab;
                            r_neg_hi <= op[1] & w_signed & opa[31];
                            r_dz     <= 1'b0;
                            r_state  <= op[1] ? S_DIV : S_MUL;
                        end
                    end else if (mt_we) begin
                        // A simultaneous start takes priority; the MT write
                        // is simply dropped in that case.
                        if (mt_sel) r_hi <= mt_data;
                        else        r_lo <= mt_data;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_fix_rem;
                        r_lo <= w_fix_quo;
                    end else begin
                        r_hi <= w_fix_prod[63:32];
                        r_lo <= w_fix_prod[31:0];
                    end
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------
    assign busy     = (r_state != S_IDLE);
    assign stall    = busy & (start | mt_we | mf_req);
    assign mf_data  = mt_sel ? r_hi : r_lo;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Scoreboard bench: each issued operation pushes its expected {div_zero, HI,
// LO} computed with plain 64-bit arithmetic; a monitor pops and compares on
// every done pulse. The issuing task also checks latency, busy/stall
// behaviour, and MT/MF interactions.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = 32'd0;
    logic        mf_req = 1'b0;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .mt_we    (mt_we),
        .mt_sel   (mt_sel),
        .mt_data  (mt_data),
        .mf_req   (mf_req),
        .mf_data  (mf_data),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {div_zero, HI, LO}
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (o)
            2'd0: begin p = sa * sb; return {1'b0, p}; end
            2'd1: begin up = ua * ub; return {1'b0, up}; end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Monitor: compare every committed result against the scoreboard.
    always @(negedge clk) begin
        if (reset && done) begin
            check("done_single_pulse", 96'(prev_done), 96'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 96'd1, 96'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_dz_hi_lo", 96'({div_zero, hi, lo}), 96'(mon_e));
            end
        end
        prev_done = done;
    end

    // Issue one operation; called and returns at a negedge.
    // mode 0: plain, 1: MFLO held from cycle 5, 2: MTHI held from cycle 5,
    // 3: MTLO asserted together with start (must be dropped).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [64:0] e;
        logic [31:0] old_lo;
        int          k;
        int          errs;
        bit          seen;
        e      = ref_op(o, a, b);
        old_lo = lo;
        op  = o;
        opa = a;
        opb = b;
        start = 1'b1;
        if (mode == 3) begin
            mt_sel  = 1'b0;
            mt_data = 32'hDEAD_BEEF;
            mt_we   = 1'b1;
        end
        #1;
        check("stall_at_start", 96'(stall), 96'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        mt_we = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        if (mode == 3) check("mt_dropped_on_start", 96'(lo), 96'(old_lo));
        k = 0; errs = 0; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) errs++;
                if (mode == 1 && k == 5) begin mt_sel = 1'b0; mf_req = 1'b1; end
                if (mode == 2 && k == 5) begin mt_sel = 1'b1; mt_data = 32'h0000_ABCD; mt_we = 1'b1; end
                if ((mode == 1 || mode == 2) && k >= 5) begin
                    #1;
                    if (stall !== 1'b1) errs++;
                end
            end
        end
        check("done_seen", 96'(seen), 96'd1);
        check("latency", 96'(k), (e[64] ? 96'd2 : 96'd34));
        check("busy_stall_inflight", 96'(errs), 96'd0);
        if (seen) check("busy_in_done", 96'(busy), 96'd0);
        if (mode == 1) begin
            #1;
            check("mf_stall_release", 96'(stall), 96'd0);
            check("mf_data_new_lo", 96'(mf_data), 96'(e[31:0]));
            mf_req = 1'b0;
        end
        if (mode == 2) begin
            #1;
            check("mt_stall_release", 96'(stall), 96'd0);
            @(posedge clk);
            #1;
            mt_we = 1'b0;
            check("mt_after_busy_hi", 96'(hi), 96'h0000_ABCD);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        // Reset state (request inputs high to show stall stays low)
        start = 1'b1; mf_req = 1'b1;
        #2;
        check("rst_hi", 96'(hi), 96'd0);
        check("rst_lo", 96'(lo), 96'd0);
        check("rst_flags", 96'({busy, done, div_zero, stall}), 96'd0);
        start = 1'b0; mf_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MTHI in IDLE
        mt_sel = 1'b1; mt_data = 32'h0000_1234; mt_we = 1'b1;
        @(posedge clk);
        #1;
        mt_we = 1'b0;
        check("mthi_hi", 96'(hi), 96'h1234);
        check("mthi_mf_data", 96'(mf_data), 96'h1234);
        @(negedge clk);

        // Directed cases, issued back-to-back in each done cycle
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5,          0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2,          0);
        do_op(2'd3, 32'd100,       32'd7,          0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  0);
        do_op(2'd3, 32'd100,       32'd0,          0);
        do_op(2'd2, 32'h8000_0000, 32'd0,          0);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000,  0);

        // Stall behaviour and MT/MF interplay
        do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0,  1);
        do_op(2'd3, 32'hCAFE_F00D, 32'd13,         2);
        do_op(2'd1, 32'd3,         32'd4,          3);

        // Reset mid-DIV
        op = 2'd2; opa = 32'h7654_3210; opb = 32'd3; start = 1'b1;
        exp_q.push_back(ref_op(2'd2, 32'h7654_3210, 32'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_hi_lo", 96'({hi, lo}), 96'd0);
        check("midrst_flags", 96'({busy, done, div_zero}), 96'd0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        check("midrst_no_done", 96'(done), 96'd0);
        reset = 1'b1;
        do_op(2'd2, 32'hFFFF_FF9C, 32'd7, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_op(ro, ra, rb, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 96'(exp_q.size()), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
